// File: rtl/newspaper_pkg.sv
// Shared types and constants for the newspaper vending controller.
// Credit and coin values are counted in nickel units (5 cents each).
package newspaper_pkg;

   typedef logic [2:0] credit_t;

   localparam logic [3:0] PRICE_NICKELS = 4'd7;
   localparam credit_t    NICKEL        = 3'd1;
   localparam credit_t    DIME          = 3'd2;
   localparam credit_t    QUARTER       = 3'd5;

   // Only the highest-value coin counts when several arrive together.
   function automatic credit_t coin_value(input logic n, input logic d, input logic q);
      credit_t v;
      if (q) begin
         v = QUARTER;
      end else if (d) begin
         v = DIME;
      end else if (n) begin
         v = NICKEL;
      end else begin
         v = 3'd0;
      end
      return v;
   endfunction

endpackage

// File: rtl/newspaper_change_enc.sv
// Maps change owed (0..4 nickels) onto the coin-return actuator lines.
module newspaper_change_enc
   import newspaper_pkg::*;
(
   input  logic [2:0] change,
   output logic       ret_n1,
   output logic       ret_d1,
   output logic       ret_d2
);

   // Change decode: at most 20 cents is ever owed.
   always_comb begin
      ret_n1 = 1'b0;
      ret_d1 = 1'b0;
      ret_d2 = 1'b0;
      case (change)
         3'd0: begin
            ret_n1 = 1'b0;
         end
         3'd1: begin
            ret_n1 = 1'b1;
         end
         3'd2: begin
            ret_d1 = 1'b1;
         end
         3'd3: begin
            ret_d1 = 1'b1;
            ret_n1 = 1'b1;
         end
         3'd4: begin
            ret_d1 = 1'b1;
            ret_d2 = 1'b1;
         end
         default: begin
            ret_n1 = 1'b0;
            ret_d1 = 1'b0;
            ret_d2 = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/newspaper.sv
// Newspaper vending controller: accumulates coin credit and releases a paper
// at 35 cents, returning any overpayment as nickel/dime pulses.
module newspaper
   import newspaper_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic N,
   input  logic D,
   input  logic Q,
   output logic R,
   output logic N1,
   output logic D1,
   output logic D2
);

   credit_t    credit_r;
   credit_t    credit_next_s;
   credit_t    coin_s;
   logic [3:0] total_s;
   logic [2:0] change_s;
   logic       sale_s;
   logic       ret_n1_s;
   logic       ret_d1_s;
   logic       ret_d2_s;

   assign coin_s  = coin_value(N, D, Q);
   assign total_s = {1'b0, credit_r} + {1'b0, coin_s};

   // Next credit and sale decision; change wraps mod 8 to total minus price.
   always_comb begin
      credit_next_s = credit_r;
      change_s      = 3'd0;
      sale_s        = 1'b0;
      if (total_s >= PRICE_NICKELS) begin
         credit_next_s = 3'd0;
         change_s      = credit_r + coin_s - PRICE_NICKELS[2:0];
         sale_s        = 1'b1;
      end else begin
         credit_next_s = total_s[2:0];
         change_s      = 3'd0;
         sale_s        = 1'b0;
      end
   end

   newspaper_change_enc u_change_enc (
      .change (change_s),
      .ret_n1 (ret_n1_s),
      .ret_d1 (ret_d1_s),
      .ret_d2 (ret_d2_s)
   );

   // Credit register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_r <= 3'd0;
      end else begin
         credit_r <= credit_next_s;
      end
   end

   // Registered release and coin-return pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         R  <= 1'b0;
         N1 <= 1'b0;
         D1 <= 1'b0;
         D2 <= 1'b0;
      end else begin
         R  <= sale_s;
         N1 <= ret_n1_s;
         D1 <= ret_d1_s;
         D2 <= ret_d2_s;
      end
   end

endmodule

// File: tb/tb_newspaper.sv
// Directed bench for the newspaper controller; outputs are checked as
// {R,N1,D1,D2} one step after each rising edge.
module tb_newspaper;

   logic clk;
   logic rst_n;
   logic N;
   logic D;
   logic Q;
   logic R;
   logic N1;
   logic D1;
   logic D2;

   int n_checks;
   int n_errors;

   newspaper dut (
      .clk   (clk),
      .rst_n (rst_n),
      .N     (N),
      .D     (D),
      .Q     (Q),
      .R     (R),
      .N1    (N1),
      .D1    (D1),
      .D2    (D2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got {R,N1,D1,D2}=%b expected %b", tag, got, exp);
      end
   endtask

   // Apply one cycle of coins (and reset level), then check the outputs.
   task automatic step(input string tag, input logic rn, input logic n, input logic d,
                       input logic q, input logic [3:0] exp);
      rst_n = rn;
      N = n;
      D = d;
      Q = q;
      @(posedge clk);
      #1;
      check_value(tag, {R, N1, D1, D2}, exp);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      N = 1'b0;
      D = 1'b0;
      Q = 1'b0;
      @(negedge clk);

      // Reset with a quarter held: ignored
      step("rst0", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      step("rst1", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
      step("idle_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

      // D, idle, Q = 35 exact
      step("dq_d",    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      step("dq_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      step("dq_q",    1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
      step("dq_pulse_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      // credit was cleared: a quarter alone must not sell
      step("dq_cleared", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
      // back-to-back: dime completes 35, next quarter starts from 0
      step("b2b_d1", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
      step("b2b_q",  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
      step("b2b_d2", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);

      // N,D,N,N then Q = 50 -> 15c back
      step("ndnn_n1", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      step("ndnn_d",  1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      step("ndnn_n2", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      step("ndnn_n3", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      step("ndnn_q",  1'b1, 1'b0, 1'b0, 1'b1, 4'b1110);
      step("ndnn_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Q, idle, N, idle, Q = 55 -> 20c back
      step("q55_q1",  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
      step("q55_i1",  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      step("q55_n",   1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      step("q55_i2",  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      step("q55_q2",  1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
      step("q55_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Held nickel counts per edge: 5+5+5+5+5+5 = 30, then D = 40 -> 5c back
      for (int i = 0; i < 6; i++) begin
         step("held_n", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      end
      step("held_d", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100);

      // Credit 10 then all coins together -> quarter only, exact 35
      step("all_d",   1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      step("all_ndq", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000);
      // D+N together at credit 0 counts as dime only: 10, then Q = 35 exact
      step("dn_pri",   1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      step("dn_pri_q", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);

      // Q,N (30) then reset discards credit, then D -> credit 10
      step("mid_q",   1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
      step("mid_n",   1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      step("mid_d",   1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      step("mid_q2",  1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
      step("mid_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
